// File: rtl/pixel_column_buffer.sv
// Pixel column buffer: keeps the two previous image lines and, for each incoming
// pixel, emits the vertically aligned column {top, mid, bottom}, its coordinates
// and frame markers for the downstream 3x3 window stage. No backpressure.
module pixel_column_buffer #(
    parameter int unsigned PIX_WIDTH  = 24,
    parameter int unsigned IMG_WIDTH  = 224,
    parameter int unsigned IMG_HEIGHT = 224,
    parameter int unsigned X_WIDTH    = $clog2(IMG_WIDTH),
    parameter int unsigned Y_WIDTH    = $clog2(IMG_HEIGHT)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [PIX_WIDTH-1:0]   idat_i,
    input  logic                   ival_i,
    output logic [3*PIX_WIDTH-1:0] odat_o,
    output logic                   oval_o,
    output logic [X_WIDTH-1:0]     ox_o,
    output logic [Y_WIDTH-1:0]     oy_o,
    output logic                   osof_o,
    output logic                   oeol_o,
    output logic                   oeof_o
);

    localparam logic [X_WIDTH-1:0] XLast = X_WIDTH'(IMG_WIDTH - 1);
    localparam logic [Y_WIDTH-1:0] YLast = Y_WIDTH'(IMG_HEIGHT - 1);

    // Line memories, deliberately not reset; stale contents are overwritten
    // during the two priming rows of every frame before they are ever emitted.
    logic [PIX_WIDTH-1:0] lb_mid_q [IMG_WIDTH];
    logic [PIX_WIDTH-1:0] lb_top_q [IMG_WIDTH];

    logic [X_WIDTH-1:0] wx_q, wx_d;
    logic [Y_WIDTH-1:0] wy_q, wy_d;

    logic [3*PIX_WIDTH-1:0] odat_q;
    logic                   oval_q, osof_q, oeol_q, oeof_q;
    logic [X_WIDTH-1:0]     ox_q;
    logic [Y_WIDTH-1:0]     oy_q;

    logic [PIX_WIDTH-1:0] mid_rd, top_rd;
    logic                 last_x, last_y, primed;

    // Asynchronous read gives the pre-write values for this cycle's address.
    assign mid_rd = lb_mid_q[wx_q];
    assign top_rd = lb_top_q[wx_q];
    assign last_x = (wx_q == XLast);
    assign last_y = (wy_q == YLast);
    assign primed = (wy_q >= Y_WIDTH'(2));

    // Write-position counters: advance per accepted pixel, wrap at line/frame end.
    always_comb begin
        wx_d = wx_q;
        wy_d = wy_q;
        if (ival_i) begin
            if (last_x) begin
                wx_d = '0;
                wy_d = last_y ? '0 : wy_q + Y_WIDTH'(1);
            end else begin
                wx_d = wx_q + X_WIDTH'(1);
            end
        end
    end

    // Counter state; reset re-starts at pixel (0,0) of a new frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wx_q <= '0;
            wy_q <= '0;
        end else begin
            wx_q <= wx_d;
            wy_q <= wy_d;
        end
    end

    // Shift the column down one line: mid moves to top, new pixel becomes mid.
    always_ff @(posedge clk_i) begin
        if (!rst_i && ival_i) begin
            lb_top_q[wx_q] <= mid_rd;
            lb_mid_q[wx_q] <= idat_i;
        end
    end

    // Output register: one cycle after the accepted pixel; data holds when idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            odat_q <= '0;
            oval_q <= 1'b0;
            osof_q <= 1'b0;
            oeol_q <= 1'b0;
            oeof_q <= 1'b0;
            ox_q   <= '0;
            oy_q   <= '0;
        end else begin
            oval_q <= ival_i && primed;
            osof_q <= ival_i && primed && (wx_q == '0) && (wy_q == Y_WIDTH'(2));
            oeol_q <= ival_i && primed && last_x;
            oeof_q <= ival_i && primed && last_x && last_y;
            if (ival_i) begin
                odat_q <= {top_rd, mid_rd, idat_i};
                ox_q   <= wx_q;
                oy_q   <= wy_q - Y_WIDTH'(2);
            end
        end
    end

    assign odat_o = odat_q;
    assign oval_o = oval_q;
    assign osof_o = osof_q;
    assign oeol_o = oeol_q;
    assign oeof_o = oeof_q;
    assign ox_o   = ox_q;
    assign oy_o   = oy_q;

endmodule
